// File: rtl/piece_mover_if.sv
// Handshake between piece_mover and its collision checker: control and move
// lines plus candidate coordinates out, collision verdict back.
interface piece_mover_if #(
  parameter int XSIZE = 3,
  parameter int YSIZE = 3
) ();
  logic                chkReset;
  logic                chkCheck;
  logic                chkLoad;
  logic                chkLeft;
  logic                chkRight;
  logic                chkDown;
  logic [3:0][XSIZE:0] chkX;
  logic [3:0][YSIZE:0] chkY;
  logic                colOut;
  logic                colDone;

  modport master (
    output chkReset, chkCheck, chkLoad, chkLeft, chkRight, chkDown, chkX, chkY,
    input  colOut, colDone
  );

  modport slave (
    input  chkReset, chkCheck, chkLoad, chkLeft, chkRight, chkDown, chkX, chkY,
    output colOut, colDone
  );
endinterface

// File: rtl/piece_mover.sv
// Moves a four-cell piece on the grid; every spawn or move is validated by an
// external collision checker before it is committed.
module piece_mover #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int XSIZE  = 3,
  parameter int YSIZE  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spawn,
  input  logic [3:0][XSIZE:0] spawnX,
  input  logic [3:0][YSIZE:0] spawnY,
  input  logic                left,
  input  logic                right,
  input  logic                down,
  input  logic                gravity,
  piece_mover_if.master       chk,
  output logic [3:0][XSIZE:0] pieceX,
  output logic [3:0][YSIZE:0] pieceY,
  output logic                active,
  output logic                busy,
  output logic                moved,
  output logic                landed,
  output logic                gameOver,
  output logic                timeoutErr
);

  if ((WIDTH > (1 << (XSIZE + 1))) || (HEIGHT > (1 << (YSIZE + 1)))) begin : g_geometry_check
    $error("piece_mover: grid does not fit the coordinate width");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ARM, S_WAIT, S_RESOLVE} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_SPAWN, CMD_LEFT, CMD_RIGHT, CMD_DOWN} cmd_t;

  localparam logic [XSIZE:0] XONE = 1;
  localparam logic [YSIZE:0] YONE = 1;

  state_t              state, state_nxt;
  cmd_t                cmd, accept;
  logic                pending_g;
  logic                col;
  logic [2:0]          wait_cnt;
  logic                timeout;
  logic                in_chk;
  logic [3:0][XSIZE:0] chk_x, new_x;
  logic [3:0][YSIZE:0] chk_y, new_y;

  // Seventh consecutive WAIT cycle without an answer forces a blocked result.
  assign timeout = (state == S_WAIT) && !chk.colDone && (wait_cnt == 3'd6);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = CMD_NONE;
    case (state)
      S_IDLE: begin
        if (!gameOver) begin
          if (spawn && !active)                 accept = CMD_SPAWN;
          else if (active && (down || pending_g)) accept = CMD_DOWN;
          else if (active && left)              accept = CMD_LEFT;
          else if (active && right)             accept = CMD_RIGHT;
        end
        if (accept != CMD_NONE) state_nxt = S_CLR;
      end
      S_CLR:     state_nxt = S_ARM;
      S_ARM:     state_nxt = S_WAIT;
      S_WAIT:    if (chk.colDone || timeout) state_nxt = S_RESOLVE;
      S_RESOLVE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_chk       = (state == S_CLR) || (state == S_ARM) || (state == S_WAIT);
    busy         = (state != S_IDLE);
    chk.chkReset = (state == S_CLR);
    chk.chkCheck = (state == S_ARM);
    chk.chkLoad  = in_chk && (cmd == CMD_SPAWN);
    chk.chkLeft  = in_chk && (cmd == CMD_LEFT);
    chk.chkRight = in_chk && (cmd == CMD_RIGHT);
    chk.chkDown  = in_chk && (cmd == CMD_DOWN);
    chk.chkX     = chk_x;
    chk.chkY     = chk_y;
    moved        = (state == S_RESOLVE) && !col;
    landed       = (state == S_RESOLVE) && col && (cmd == CMD_DOWN);
  end

  always_comb begin
    new_x = chk_x;
    new_y = chk_y;
    for (int unsigned i = 0; i < 4; i++) begin
      case (cmd)
        CMD_LEFT:  new_x[i] = chk_x[i] - XONE;
        CMD_RIGHT: new_x[i] = chk_x[i] + XONE;
        CMD_DOWN:  new_y[i] = chk_y[i] + YONE;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd        <= CMD_NONE;
      pending_g  <= 1'b0;
      col        <= 1'b0;
      wait_cnt   <= '0;
      chk_x      <= '0;
      chk_y      <= '0;
      pieceX     <= '0;
      pieceY     <= '0;
      active     <= 1'b0;
      gameOver   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      // A gravity tick wins over the clear so a tick in the accept cycle survives.
      if (gravity)                 pending_g <= 1'b1;
      else if (accept == CMD_DOWN) pending_g <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept != CMD_NONE) begin
            cmd      <= accept;
            wait_cnt <= '0;
            chk_x    <= (accept == CMD_SPAWN) ? spawnX : pieceX;
            chk_y    <= (accept == CMD_SPAWN) ? spawnY : pieceY;
          end
        end
        S_WAIT: begin
          if (chk.colDone) begin
            col <= chk.colOut;
          end else if (timeout) begin
            col        <= 1'b1;
            timeoutErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_RESOLVE: begin
          if (!col) begin
            pieceX <= new_x;
            pieceY <= new_y;
            if (cmd == CMD_SPAWN) active <= 1'b1;
          end else if (cmd == CMD_DOWN) begin
            active <= 1'b0;
          end else if (cmd == CMD_SPAWN) begin
            gameOver <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_mover.sv
// Bench for piece_mover: directed scenarios plus random command streams against
// a grid-level model, with a bounds-checking collision checker attached.
`timescale 1ns/1ps
module tb_piece_mover;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 8;
  localparam int XSIZE  = 3;
  localparam int YSIZE  = 3;

  localparam int K_NONE = 0, K_SPAWN = 1, K_LEFT = 2, K_RIGHT = 3, K_DOWN = 4;
  localparam int CM_BOUNDS = 0, CM_FORCE = 1, CM_SILENT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spawn = 1'b0, left = 1'b0, right = 1'b0, down = 1'b0, gravity = 1'b0;
  logic [3:0][XSIZE:0] spawnX = '0;
  logic [3:0][YSIZE:0] spawnY = '0;
  logic [3:0][XSIZE:0] pieceX;
  logic [3:0][YSIZE:0] pieceY;
  logic active, busy, moved, landed, gameOver, timeoutErr;

  piece_mover_if #(.XSIZE(XSIZE), .YSIZE(YSIZE)) chk_bus ();

  piece_mover #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XSIZE(XSIZE), .YSIZE(YSIZE)) dut (
    .clk(clk), .reset(reset), .spawn(spawn), .spawnX(spawnX), .spawnY(spawnY),
    .left(left), .right(right), .down(down), .gravity(gravity), .chk(chk_bus),
    .pieceX(pieceX), .pieceY(pieceY), .active(active), .busy(busy), .moved(moved),
    .landed(landed), .gameOver(gameOver), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int chk_mode = CM_BOUNDS;
  int ck_cnt;

  int m_x[4], m_y[4];
  bit m_active, m_over, m_tout, m_pend;

  // Checker: answers two cycles after chkCheck; a cell leaving the grid collides.
  function automatic bit ck_blocked();
    int nx, ny;
    bit b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nx = int'(chk_bus.chkX[i]) + (chk_bus.chkRight ? 1 : 0) - (chk_bus.chkLeft ? 1 : 0);
      ny = int'(chk_bus.chkY[i]) + (chk_bus.chkDown ? 1 : 0);
      if (nx < 0 || nx >= WIDTH || ny >= HEIGHT) b = 1'b1;
    end
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_bus.colDone <= 1'b0;
      chk_bus.colOut  <= 1'b0;
      ck_cnt          <= 0;
    end else if (chk_bus.chkReset) begin
      chk_bus.colDone <= 1'b0;
      chk_bus.colOut  <= 1'b0;
      ck_cnt          <= 0;
    end else if (chk_bus.chkCheck) begin
      ck_cnt <= 1;
    end else if (ck_cnt == 1) begin
      ck_cnt <= 2;
    end else if (ck_cnt == 2) begin
      ck_cnt <= 0;
      if (chk_mode != CM_SILENT) begin
        chk_bus.colDone <= 1'b1;
        chk_bus.colOut  <= (chk_mode == CM_FORCE) || ck_blocked();
      end
    end
  end

  function automatic logic [75:0] all_outs();
    return {chk_bus.chkReset, chk_bus.chkCheck, chk_bus.chkLoad, chk_bus.chkLeft,
            chk_bus.chkRight, chk_bus.chkDown, chk_bus.chkX, chk_bus.chkY,
            pieceX, pieceY, active, busy, moved, landed, gameOver, timeoutErr};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_active = 0; m_over = 0; m_tout = 0; m_pend = 0;
  endfunction

  function automatic int model_pick(bit sp, bit l, bit r, bit d);
    if (m_over) return K_NONE;
    if (sp && !m_active) return K_SPAWN;
    if (!m_active) return K_NONE;
    if (d || m_pend) return K_DOWN;
    if (l) return K_LEFT;
    if (r) return K_RIGHT;
    return K_NONE;
  endfunction

  // Starts and ends on a falling edge with the mover idle.
  task automatic step(input bit sp, input bit l, input bit r, input bit d, input bit g,
                      input bit gb, input int mode, input string tag);
    int pick, dx, dy, k, busy_n, n_mv, n_ld, pulse_k;
    bit col, gb_eff, exp_mv, exp_ld;
    int tx[4], ty[4];
    logic [3:0][3:0] src_x, src_y, ev_x, ev_y;
    logic [3:0] lines;
    pick   = model_pick(sp, l, r, d);
    gb_eff = gb && (pick != K_NONE);
    chk_mode = mode;
    dx = (pick == K_LEFT) ? -1 : (pick == K_RIGHT) ? 1 : 0;
    dy = (pick == K_DOWN) ? 1 : 0;
    col = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_x[i] = (pick == K_SPAWN) ? spawnX[i] : 4'(m_x[i]);
      src_y[i] = (pick == K_SPAWN) ? spawnY[i] : 4'(m_y[i]);
      tx[i] = int'(src_x[i]) + dx;
      ty[i] = int'(src_y[i]) + dy;
      if (tx[i] < 0 || tx[i] >= WIDTH || ty[i] >= HEIGHT) col = 1'b1;
    end
    if (mode != CM_BOUNDS) col = 1'b1;

    spawn = sp; left = l; right = r; down = d; gravity = g;
    @(negedge clk);
    spawn = 0; left = 0; right = 0; down = 0; gravity = gb_eff;
    if (pick == K_DOWN) m_pend = 0;
    if (g || gb_eff) m_pend = 1;

    if (pick == K_NONE) begin
      checks++;
      if ({busy, moved, landed} !== 3'b000)
        $display("FAIL %s dropped: busy/moved/landed=%b expected 000", tag, {busy, moved, landed});
      return;
    end

    lines = {pick == K_SPAWN, pick == K_LEFT, pick == K_RIGHT, pick == K_DOWN};
    checks++;
    if ({chk_bus.chkReset, chk_bus.chkLoad, chk_bus.chkLeft, chk_bus.chkRight, chk_bus.chkDown} !== {1'b1, lines}) begin
      failures++;
      $display("FAIL %s clr_lines: got %b expected %b", tag,
               {chk_bus.chkReset, chk_bus.chkLoad, chk_bus.chkLeft, chk_bus.chkRight, chk_bus.chkDown}, {1'b1, lines});
    end
    checks++;
    if ({chk_bus.chkX, chk_bus.chkY} !== {src_x, src_y}) begin
      failures++;
      $display("FAIL %s chk_coords: got %h expected %h", tag, {chk_bus.chkX, chk_bus.chkY}, {src_x, src_y});
    end

    k = 1; busy_n = 0; n_mv = 0; n_ld = 0; pulse_k = 0;
    while (busy === 1'b1 && k <= 40) begin
      busy_n++;
      if (moved === 1'b1) begin n_mv++; pulse_k = k; end
      if (landed === 1'b1) begin n_ld++; pulse_k = k; end
      if (k == 2) begin
        checks++;
        if ({chk_bus.chkReset, chk_bus.chkCheck, chk_bus.chkLoad, chk_bus.chkLeft, chk_bus.chkRight, chk_bus.chkDown} !== {2'b01, lines}) begin
          failures++;
          $display("FAIL %s arm_lines: got %b expected %b", tag,
                   {chk_bus.chkReset, chk_bus.chkCheck, chk_bus.chkLoad, chk_bus.chkLeft, chk_bus.chkRight, chk_bus.chkDown}, {2'b01, lines});
        end
      end
      @(negedge clk);
      gravity = 0;
      k++;
    end

    exp_mv = !col;
    exp_ld = col && (pick == K_DOWN);
    checks++;
    if (k > 40) begin failures++; $display("FAIL %s busy_bound: still busy after %0d cycles, required idle", tag, k - 1); end
    checks++;
    if (busy_n != ((mode == CM_SILENT) ? 10 : 6)) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_n, (mode == CM_SILENT) ? 10 : 6);
    end
    checks++;
    if (n_mv != int'(exp_mv)) begin failures++; $display("FAIL %s moved_pulses: got %0d expected %0d", tag, n_mv, exp_mv); end
    checks++;
    if (n_ld != int'(exp_ld)) begin failures++; $display("FAIL %s landed_pulses: got %0d expected %0d", tag, n_ld, exp_ld); end
    if ((exp_mv || exp_ld) && mode != CM_SILENT) begin
      checks++;
      if (pulse_k - 1 != 5) begin failures++; $display("FAIL %s pulse_latency: got %0d expected 5", tag, pulse_k - 1); end
    end

    if (!col) begin
      for (int i = 0; i < 4; i++) begin m_x[i] = tx[i]; m_y[i] = ty[i]; end
      if (pick == K_SPAWN) m_active = 1;
    end else if (pick == K_DOWN) begin
      m_active = 0;
    end else if (pick == K_SPAWN) begin
      m_over = 1;
    end
    if (mode == CM_SILENT) m_tout = 1;

    for (int i = 0; i < 4; i++) begin ev_x[i] = 4'(m_x[i]); ev_y[i] = 4'(m_y[i]); end
    checks++;
    if ({pieceX, pieceY} !== {ev_x, ev_y}) begin
      failures++;
      $display("FAIL %s position: got %h expected %h", tag, {pieceX, pieceY}, {ev_x, ev_y});
    end
    checks++;
    if ({active, gameOver, timeoutErr} !== {m_active, m_over, m_tout}) begin
      failures++;
      $display("FAIL %s flags(active,gameOver,timeoutErr): got %b expected %b", tag,
               {active, gameOver, timeoutErr}, {m_active, m_over, m_tout});
    end
  endtask

  task automatic set_spawn(input int x0, input int y0);
    for (int i = 0; i < 4; i++) begin
      spawnX[i] = 4'(x0 + i);
      spawnY[i] = 4'(y0);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    reset = 0;
    model_clear();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_spawn;
    logic [3:0][3:0] ex;
    ex = {4'd5, 4'd4, 4'd3, 4'd2};
    set_spawn(2, 0);
    step(1, 0, 0, 0, 0, 0, CM_BOUNDS, "spawn");
    checks++;
    if ({pieceX, active} !== {ex, 1'b1}) begin
      failures++;
      $display("FAIL spawn_result: got %h expected %h", {pieceX, active}, {ex, 1'b1});
    end
  endtask

  task automatic test_left_blocked;
    step(0, 1, 0, 0, 0, 0, CM_BOUNDS, "left1");
    step(0, 1, 0, 0, 0, 0, CM_BOUNDS, "left2");
    step(0, 1, 0, 0, 0, 0, CM_BOUNDS, "left_wall");
    checks++;
    if ({pieceX[0], active, busy} !== {4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL left_wall_state: got %h expected %h", {pieceX[0], active, busy}, {4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_gravity_busy;
    for (int n = 0; n < 6; n++) step(0, 0, 0, 1, 0, 0, CM_BOUNDS, "descend");
    step(0, 0, 1, 0, 0, 1, CM_BOUNDS, "right_with_gravity");
    step(0, 0, 0, 0, 0, 0, CM_BOUNDS, "pending_down");
    checks++;
    if ({pieceX[0], pieceY[0]} !== {4'd1, 4'd7}) begin
      failures++;
      $display("FAIL gravity_result: got %h expected %h", {pieceX[0], pieceY[0]}, {4'd1, 4'd7});
    end
    step(0, 0, 0, 0, 0, 0, CM_BOUNDS, "pending_cleared");
  endtask

  task automatic test_land;
    step(0, 0, 0, 1, 0, 0, CM_BOUNDS, "land");
    checks++;
    if (active !== 1'b0) begin failures++; $display("FAIL land_active: got %b expected 0", active); end
    step(0, 1, 0, 0, 0, 0, CM_BOUNDS, "left_after_land");
    checks++;
    if (pieceX[0] !== 4'd1) begin failures++; $display("FAIL land_pos: got %0d expected 1", pieceX[0]); end
  endtask

  task automatic test_game_over;
    set_spawn(2, 0);
    step(1, 0, 0, 0, 0, 0, CM_FORCE, "spawn_blocked");
    checks++;
    if ({gameOver, active} !== 2'b10) begin failures++; $display("FAIL over_flags: got %b expected 10", {gameOver, active}); end
    step(1, 0, 0, 0, 0, 0, CM_BOUNDS, "spawn_after_over");
    step(0, 1, 0, 0, 0, 0, CM_BOUNDS, "left_after_over");
    reset = 1;
    #1;
    checks++;
    if (gameOver !== 1'b0) begin failures++; $display("FAIL over_reset: gameOver=%b expected 0", gameOver); end
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_timeout;
    set_spawn(2, 0);
    step(1, 0, 0, 0, 0, 0, CM_BOUNDS, "spawn_for_timeout");
    step(0, 0, 1, 0, 0, 0, CM_SILENT, "silent_right");
    checks++;
    if ({timeoutErr, pieceX[0]} !== {1'b1, 4'd2}) begin
      failures++;
      $display("FAIL timeout_state: got %h expected %h", {timeoutErr, pieceX[0]}, {1'b1, 4'd2});
    end
    chk_mode = CM_SILENT;
    left = 1;
    @(negedge clk);
    left = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL wait_busy: busy=%b expected 1", busy); end
    reset = 1;
    #1;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_in_wait: got %h expected 0", all_outs()); end
    @(negedge clk);
    reset = 0;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, moved, landed} !== 3'b000) begin
        failures++;
        $display("FAIL after_wait_reset: busy/moved/landed=%b expected 000", {busy, moved, landed});
      end
    end
  endtask

  task automatic test_random;
    bit sp, l, r, d, g, gb;
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_clear();
    for (int n = 0; n < 80; n++) begin
      if (m_over) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_clear();
      end
      sp = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 3) == 0);
      g  = ($urandom_range(0, 5) == 0);
      gb = ($urandom_range(0, 5) == 0);
      set_spawn(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
      step(sp, l, r, d, g, gb, CM_BOUNDS, "random");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_spawn();
    test_left_blocked();
    test_gravity_busy();
    test_land();
    test_game_over();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
